// File: rtl/key_debounce_repeat_pkg.sv
// key_debounce_repeat_pkg: FSM state encoding, default 50 MHz board timing, counter sizing helper
package key_debounce_repeat_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} state_t;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 50_000;
    localparam int DEF_HOLD_CYCLES = 25_000_000;
    localparam int DEF_REPEAT_CYCLES = 5_000_000;
    function automatic int cnt_width(input int a, input int b);
        return $clog2(a > b ? a : b) + 1;
    endfunction
endpackage

// File: rtl/key_debounce_repeat_sync_debounce.sv
// key_sync_debounce: synchronises the active-low raw key and accepts a level only after it is stable
module key_sync_debounce
    import key_debounce_repeat_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic in_key,
    output logic pressed,
    output logic pressed_next,
    output logic press_edge
);
    localparam int DW = cnt_width(DEBOUNCE_CYCLES, 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0] cnt;
    logic key_dn, differ, fire;
    assign key_dn = ~sync[SYNC_STAGES-1];
    assign differ = key_dn != pressed;
    assign fire = differ && cnt == DW'(DEBOUNCE_CYCLES - 1);
    assign pressed_next = fire ? key_dn : pressed;
    assign press_edge = fire && key_dn;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
            cnt <= '0;
            pressed <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in_key};
            cnt <= (differ && !fire) ? cnt + 1'b1 : '0;
            pressed <= pressed_next;
        end
    end
endmodule

// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat: debounced key to single-cycle press pulses with hold-delayed auto-repeat
module key_debounce_repeat
    import key_debounce_repeat_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_key,
    output logic out_key,
    output logic pressed,
    output logic repeating
);
    localparam int CW = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
    state_t state, state_n;
    logic [CW-1:0] hold_cnt, hold_n, rep_cnt, rep_n;
    logic out_n, repeating_n, pressed_next, press_edge;
    key_sync_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .clk(clk),
        .rst(rst),
        .in_key(in_key),
        .pressed(pressed),
        .pressed_next(pressed_next),
        .press_edge(press_edge)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hold_cnt <= '0;
            rep_cnt <= '0;
            out_key <= 1'b0;
            repeating <= 1'b0;
        end else begin
            state <= state_n;
            hold_cnt <= hold_n;
            rep_cnt <= rep_n;
            out_key <= out_n;
            repeating <= repeating_n;
        end
    end
    always_comb begin
        state_n = state;
        hold_n = hold_cnt;
        rep_n = rep_cnt;
        out_n = 1'b0;
        repeating_n = repeating;
        case (state)
            IDLE: begin
                repeating_n = 1'b0;
                if (press_edge) begin
                    out_n = 1'b1;
                    hold_n = '0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (!pressed_next) state_n = IDLE;
                else if (hold_cnt != CW'(HOLD_CYCLES - 1)) hold_n = hold_cnt + 1'b1;
                else if (REPEAT_EN != 0) begin
                    out_n = 1'b1;
                    repeating_n = 1'b1;
                    rep_n = '0;
                    state_n = REPEAT;
                end
            end
            REPEAT: begin
                if (!pressed_next) begin
                    state_n = IDLE;
                    repeating_n = 1'b0;
                end else if (rep_cnt == CW'(REPEAT_CYCLES - 1)) begin
                    out_n = 1'b1;
                    rep_n = '0;
                end else rep_n = rep_cnt + 1'b1;
            end
            default: begin
                state_n = IDLE;
                repeating_n = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_key_debounce_repeat.sv
// tb_key_debounce_repeat: directed stimulus, per-cycle model compare plus literal event masks
module tb_key_debounce_repeat;
    localparam int SYNC = 2, DEB = 4, HOLD = 10, REP = 3;
    logic clk = 1'b0, rst = 1'b1, in_key = 1'b1;
    logic out_a, pressed_a, rep_a, out_b, pressed_b, rep_b;
    int checks = 0, errors = 0;
    logic [SYNC-1:0] sq = '1;
    int run_len = 0, since = 0;
    logic m_pressed = 1'b0, chk_en = 1'b0;
    logic [63:0] pa, oa, ra, ob, rb;
    always #5 clk = ~clk;
    key_debounce_repeat #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1)
    ) dut_a (
        .clk(clk), .rst(rst), .in_key(in_key), .out_key(out_a), .pressed(pressed_a), .repeating(rep_a)
    );
    key_debounce_repeat #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(0)
    ) dut_b (
        .clk(clk), .rst(rst), .in_key(in_key), .out_key(out_b), .pressed(pressed_b), .repeating(rep_b)
    );
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [63:0] b(input int n);
        return 64'd1 << n;
    endfunction
    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction
    // model: key accepted after DEB consecutive differing synced samples; pulses by elapsed time since press
    task automatic step(input logic r, input logic k_in);
        logic kd;
        rst = r;
        in_key = k_in;
        @(posedge clk);
        #1;
        if (r) begin
            sq = '1;
            run_len = 0;
            m_pressed = 1'b0;
            since = 0;
        end else begin
            kd = ~sq[SYNC-1];
            run_len = (kd != m_pressed) ? run_len + 1 : 0;
            if (run_len == DEB) begin
                m_pressed = kd;
                run_len = 0;
                since = 0;
            end else since++;
            sq = {sq[SYNC-2:0], k_in};
        end
    endtask
    always @(negedge clk) begin
        if (chk_en) begin
            check("pressed_a", 64'(pressed_a), 64'(m_pressed));
            check("pressed_b", 64'(pressed_b), 64'(m_pressed));
            check("out_a", 64'(out_a), 64'(m_pressed && (since == 0 || (since >= HOLD && (since - HOLD) % REP == 0))));
            check("rep_a", 64'(rep_a), 64'(m_pressed && since >= HOLD));
            check("out_b", 64'(out_b), 64'(m_pressed && since == 0));
            check("rep_b", 64'(rep_b), 64'd0);
        end
    end
    task automatic run(input int len, input int rel_at, input int glitch_at, input int rst_at, input bit bounce);
        pa = '0; oa = '0; ra = '0; ob = '0; rb = '0;
        for (int c = 0; c < len; c++) begin
            pa[c] = pressed_a; oa[c] = out_a; ra[c] = rep_a; ob[c] = out_b; rb[c] = rep_b;
            step(c == rst_at || c == rst_at + 1, bounce ? (c % 4 == 3) : (c >= rel_at || c == glitch_at));
        end
    endtask
    initial begin
        repeat (3) step(1'b1, 1'b1);
        chk_en = 1'b1;
        check("rst_pressed", 64'(pressed_a), 64'd0);
        check("rst_out", 64'(out_a), 64'd0);
        check("rst_rep", 64'(rep_a), 64'd0);
        run(50, 0, -10, -10, 1'b0);
        check("t1_pressed", pa, 64'd0);
        check("t1_out", oa, 64'd0);
        run(30, 8, -10, -10, 1'b0);
        check("t2_pressed", pa, rng(6, 13));
        check("t2_out", oa, b(6));
        check("t2_rep", ra, 64'd0);
        run(40, 99, -10, -10, 1'b1);
        check("t3_pressed", pa, 64'd0);
        check("t3_out", oa, 64'd0);
        run(12, 0, -10, -10, 1'b0);
        run(40, 30, -10, -10, 1'b0);
        check("t4_pressed", pa, rng(6, 35));
        check("t4_out", oa, b(6) | b(16) | b(19) | b(22) | b(25) | b(28) | b(31) | b(34));
        check("t4_rep", ra, rng(16, 35));
        check("t4_out_norep", ob, b(6));
        check("t4_rep_norep", rb, 64'd0);
        run(12, 0, -10, -10, 1'b0);
        run(50, 99, -10, 20, 1'b0);
        check("t5_pressed", pa, rng(6, 20) | rng(28, 49));
        check("t5_out", oa, b(6) | b(16) | b(19) | b(28) | b(38) | b(41) | b(44) | b(47));
        check("t5_rep", ra, rng(16, 20) | rng(38, 49));
        check("t5_out_norep", ob, b(6) | b(28));
        run(12, 0, -10, -10, 1'b0);
        run(40, 99, 20, -10, 1'b0);
        check("t6_pressed", pa, rng(6, 39));
        check("t6_out", oa, b(6) | b(16) | b(19) | b(22) | b(25) | b(28) | b(31) | b(34) | b(37));
        check("t6_rep", ra, rng(16, 39));
        check("t6_out_norep", ob, b(6));
        run(12, 0, -10, -10, 1'b0);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
